// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//   Merges result streams from the ALU and the load/store buffer onto a single
//   registered common data bus. Each source has its own small FIFO. One head
//   is granted per enabled cycle, alternating between the sources when both
//   have work.
//
// Ports
//   clk_in            clock, all state updates on the rising edge
//   rst_in            asynchronous active-high reset
//   rdy_in            global enable; low freezes all state
//   clr_in            synchronous flush (misprediction), overrides rdy_in
//   alu_valid/_rob_index/_result   ALU result offer
//   alu_ready         ALU queue has room this cycle
//   lsb_valid/_rob_index/_result   load/store result offer
//   lsb_ready         LSB queue has room this cycle
//   cdb_valid/_rob_index/_result   registered broadcast
//   cdb_src           source of the broadcast: 0 = ALU, 1 = LSB
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// cdb_arbiter_fifo
//   Per-source queue of {rob_index, result}. Pointers wrap naturally because
//   DEPTH is a power of two. push_i/pop_i arrive already qualified by the
//   parent; flush_i empties the queue and takes precedence over both.
//
// Ports
//   clk_i, rst_i      clock and asynchronous active-high reset
//   flush_i           empty the queue on the next edge
//   push_i            write {rob_i, data_i} at the tail
//   pop_i             advance the head (caller guarantees non-empty)
//   rob_o, data_o     current head entry
//   count_o           number of resident entries, 0..DEPTH
// ---------------------------------------------------------------------------
module cdb_arbiter_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ROB_W  = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [ROB_W-1:0]         rob_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic [ROB_W-1:0]         rob_o,
  output logic [DATA_W-1:0]        data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ROB_W-1:0]  rob_mem_q  [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only visible once counted.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      rob_mem_q[wr_ptr_q]  <= rob_i;
      data_mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign rob_o   = rob_mem_q[rd_ptr_q];
  assign data_o  = data_mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

module cdb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ROB_W      = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clr_in,

  input  logic              alu_valid,
  input  logic [ROB_W-1:0]  alu_rob_index,
  input  logic [DATA_W-1:0] alu_result,
  output logic              alu_ready,

  input  logic              lsb_valid,
  input  logic [ROB_W-1:0]  lsb_rob_index,
  input  logic [DATA_W-1:0] lsb_result,
  output logic              lsb_ready,

  output logic              cdb_valid,
  output logic [ROB_W-1:0]  cdb_rob_index,
  output logic [DATA_W-1:0] cdb_result,
  output logic              cdb_src
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSB = 1'b1;

  logic [CNT_W-1:0]  alu_cnt, lsb_cnt;
  logic [ROB_W-1:0]  alu_head_rob, lsb_head_rob;
  logic [DATA_W-1:0] alu_head_data, lsb_head_data;

  logic advance;
  logic alu_push, lsb_push;
  logic alu_pop,  lsb_pop;
  logic alu_nempty, lsb_nempty;
  logic any_grant;
  logic grant_src;

  logic              cdb_valid_q, cdb_valid_d;
  logic [ROB_W-1:0]  cdb_rob_q,   cdb_rob_d;
  logic [DATA_W-1:0] cdb_data_q,  cdb_data_d;
  logic              cdb_src_q,   cdb_src_d;
  logic              last_grant_q, last_grant_d;

  // Ready reflects occupancy before any same-cycle pop, so a full queue
  // refuses an offer even in the cycle it is being drained.
  assign alu_ready = (alu_cnt != FULL_CNT);
  assign lsb_ready = (lsb_cnt != FULL_CNT);

  assign advance  = rdy_in && !clr_in;
  assign alu_push = alu_valid && alu_ready && advance;
  assign lsb_push = lsb_valid && lsb_ready && advance;

  // Emptiness also uses the pre-edge count: a freshly pushed entry cannot be
  // granted in the same cycle it arrives.
  assign alu_nempty = (alu_cnt != '0);
  assign lsb_nempty = (lsb_cnt != '0);

  always_comb begin
    any_grant = advance && (alu_nempty || lsb_nempty);
    grant_src = SRC_ALU;
    if (alu_nempty && lsb_nempty) begin
      grant_src = ~last_grant_q;
    end else if (lsb_nempty) begin
      grant_src = SRC_LSB;
    end
  end

  assign alu_pop = any_grant && (grant_src == SRC_ALU);
  assign lsb_pop = any_grant && (grant_src == SRC_LSB);

  cdb_arbiter_fifo #(
    .DATA_W (DATA_W),
    .ROB_W  (ROB_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_alu_fifo (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .flush_i (clr_in),
    .push_i  (alu_push),
    .pop_i   (alu_pop),
    .rob_i   (alu_rob_index),
    .data_i  (alu_result),
    .rob_o   (alu_head_rob),
    .data_o  (alu_head_data),
    .count_o (alu_cnt)
  );

  cdb_arbiter_fifo #(
    .DATA_W (DATA_W),
    .ROB_W  (ROB_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_lsb_fifo (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .flush_i (clr_in),
    .push_i  (lsb_push),
    .pop_i   (lsb_pop),
    .rob_i   (lsb_rob_index),
    .data_i  (lsb_result),
    .rob_o   (lsb_head_rob),
    .data_o  (lsb_head_data),
    .count_o (lsb_cnt)
  );

  always_comb begin
    cdb_valid_d  = cdb_valid_q;
    cdb_rob_d    = cdb_rob_q;
    cdb_data_d   = cdb_data_q;
    cdb_src_d    = cdb_src_q;
    last_grant_d = last_grant_q;
    if (clr_in) begin
      cdb_valid_d  = 1'b0;
      last_grant_d = SRC_LSB;
    end else if (rdy_in) begin
      if (any_grant) begin
        cdb_valid_d  = 1'b1;
        cdb_src_d    = grant_src;
        last_grant_d = grant_src;
        if (grant_src == SRC_LSB) begin
          cdb_rob_d  = lsb_head_rob;
          cdb_data_d = lsb_head_data;
        end else begin
          cdb_rob_d  = alu_head_rob;
          cdb_data_d = alu_head_data;
        end
      end else begin
        cdb_valid_d = 1'b0;
      end
    end
  end

  // last_grant resets to LSB so the ALU wins the first tie.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cdb_valid_q  <= 1'b0;
      cdb_rob_q    <= '0;
      cdb_data_q   <= '0;
      cdb_src_q    <= SRC_ALU;
      last_grant_q <= SRC_LSB;
    end else begin
      cdb_valid_q  <= cdb_valid_d;
      cdb_rob_q    <= cdb_rob_d;
      cdb_data_q   <= cdb_data_d;
      cdb_src_q    <= cdb_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign cdb_valid     = cdb_valid_q;
  assign cdb_rob_index = cdb_rob_q;
  assign cdb_result    = cdb_data_q;
  assign cdb_src       = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ROB_W  = 4;

  logic              clk_in;
  logic              rst_in;
  logic              rdy_in;
  logic              clr_in;
  logic              alu_valid;
  logic [ROB_W-1:0]  alu_rob_index;
  logic [DATA_W-1:0] alu_result;
  logic              alu_ready;
  logic              lsb_valid;
  logic [ROB_W-1:0]  lsb_rob_index;
  logic [DATA_W-1:0] lsb_result;
  logic              lsb_ready;
  logic              cdb_valid;
  logic [ROB_W-1:0]  cdb_rob_index;
  logic [DATA_W-1:0] cdb_result;
  logic              cdb_src;

  int checks   = 0;
  int failures = 0;

  cdb_arbiter #(
    .DATA_W     (DATA_W),
    .ROB_W      (ROB_W),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .clr_in        (clr_in),
    .alu_valid     (alu_valid),
    .alu_rob_index (alu_rob_index),
    .alu_result    (alu_result),
    .alu_ready     (alu_ready),
    .lsb_valid     (lsb_valid),
    .lsb_rob_index (lsb_rob_index),
    .lsb_result    (lsb_result),
    .lsb_ready     (lsb_ready),
    .cdb_valid     (cdb_valid),
    .cdb_rob_index (cdb_rob_index),
    .cdb_result    (cdb_result),
    .cdb_src       (cdb_src)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    rdy_in        = 1'b1;
    clr_in        = 1'b0;
    alu_valid     = 1'b0;
    alu_rob_index = '0;
    alu_result    = '0;
    lsb_valid     = 1'b0;
    lsb_rob_index = '0;
    lsb_result    = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  // Offers ALU entry i (rob i, A000_000i) and LSB entry i (rob 8+i,
  // B000_000i) on each of n consecutive edges, then withdraws both.
  task automatic load_both(input int n);
    for (int i = 0; i < n; i++) begin
      alu_valid = 1'b1; alu_rob_index = 4'(i);     alu_result = 32'hA000_0000 + 32'(i);
      lsb_valid = 1'b1; lsb_rob_index = 4'(8 + i); lsb_result = 32'hB000_0000 + 32'(i);
      step();
    end
    alu_valid = 1'b0;
    lsb_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_in = 1'b1;
    #3;
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", cdb_valid); end
    checks++; if (cdb_rob_index !== 4'd0) begin failures++; $display("FAIL reset_rob got=%0h exp=0", cdb_rob_index); end
    checks++; if (cdb_result !== 32'd0) begin failures++; $display("FAIL reset_result got=%0h exp=0", cdb_result); end
    checks++; if (cdb_src !== 1'b0) begin failures++; $display("FAIL reset_src got=%0h exp=0", cdb_src); end
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL reset_alu_ready got=%0h exp=1", alu_ready); end
    checks++; if (lsb_ready !== 1'b1) begin failures++; $display("FAIL reset_lsb_ready got=%0h exp=1", lsb_ready); end
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    alu_valid = 1'b1; alu_rob_index = 4'd3; alu_result = 32'hDEAD_BEEF;
    step();
    alu_valid = 1'b0;
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL single_nobypass got=%0h exp=0", cdb_valid); end
    step();
    checks++; if (cdb_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0h exp=1", cdb_valid); end
    checks++; if (cdb_rob_index !== 4'd3) begin failures++; $display("FAIL single_rob got=%0h exp=3", cdb_rob_index); end
    checks++; if (cdb_result !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_result got=%0h exp=deadbeef", cdb_result); end
    checks++; if (cdb_src !== 1'b0) begin failures++; $display("FAIL single_src got=%0h exp=0", cdb_src); end
    step();
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL single_oneshot got=%0h exp=0", cdb_valid); end
  endtask

  task automatic test_tie();
    do_reset();
    alu_valid = 1'b1; alu_rob_index = 4'd1; alu_result = 32'h1111_0001;
    lsb_valid = 1'b1; lsb_rob_index = 4'd2; lsb_result = 32'h2222_0002;
    step();
    alu_valid = 1'b0; lsb_valid = 1'b0;
    step();
    checks++; if ({cdb_valid, cdb_src, cdb_rob_index} !== {1'b1, 1'b0, 4'd1}) begin
      failures++; $display("FAIL tie_first got=v%0h s%0h r%0h exp=v1 s0 r1", cdb_valid, cdb_src, cdb_rob_index); end
    checks++; if (cdb_result !== 32'h1111_0001) begin failures++; $display("FAIL tie_first_result got=%0h exp=11110001", cdb_result); end
    step();
    checks++; if ({cdb_valid, cdb_src, cdb_rob_index} !== {1'b1, 1'b1, 4'd2}) begin
      failures++; $display("FAIL tie_second got=v%0h s%0h r%0h exp=v1 s1 r2", cdb_valid, cdb_src, cdb_rob_index); end
    checks++; if (cdb_result !== 32'h2222_0002) begin failures++; $display("FAIL tie_second_result got=%0h exp=22220002", cdb_result); end
    step();
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL tie_drained got=%0h exp=0", cdb_valid); end
  endtask

  // ALU-only traffic drains one per cycle, so the queue never backs up and
  // every entry follows its push by exactly one edge.
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      alu_valid = 1'b1; alu_rob_index = 4'(5 + i); alu_result = 32'h0000_0100 + 32'(i);
      step();
      checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%0h exp=1", i, alu_ready); end
      if (i == 0) begin
        checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL b2b_first got=%0h exp=0", cdb_valid); end
      end else begin
        checks++; if ({cdb_valid, cdb_src, cdb_rob_index, cdb_result} !== {1'b1, 1'b0, 4'(4 + i), 32'h0000_0100 + 32'(i - 1)}) begin
          failures++; $display("FAIL b2b_entry[%0d] got=v%0h r%0h d%0h exp=v1 r%0h d%0h", i - 1, cdb_valid, cdb_rob_index, cdb_result, 4 + i, 32'h100 + i - 1); end
      end
    end
    alu_valid = 1'b0;
    step();
    checks++; if ({cdb_valid, cdb_rob_index, cdb_result} !== {1'b1, 4'd9, 32'h0000_0104}) begin
      failures++; $display("FAIL b2b_last got=v%0h r%0h d%0h exp=v1 r9 d104", cdb_valid, cdb_rob_index, cdb_result); end
    step();
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%0h exp=0", cdb_valid); end
  endtask

  // Both sources offer every cycle for 7 edges. Grants alternate starting
  // with ALU, so LSB fills after edge 6 (its edge-7 offer, L6, is dropped)
  // and ALU fills after edge 7. Expected broadcast order:
  // A0 L0 A1 L1 A2 L2 A3 L3 A4 L4 A5 L5 A6, on edges 2..14.
  task automatic test_fill();
    logic       exp_v;
    logic       exp_s;
    logic [3:0] exp_r;
    logic [31:0] exp_d;
    int k;
    do_reset();
    for (int e = 1; e <= 15; e++) begin
      if (e <= 7) begin
        alu_valid = 1'b1; alu_rob_index = 4'(e - 1);     alu_result = 32'hA000_0000 + 32'(e - 1);
        lsb_valid = 1'b1; lsb_rob_index = 4'(8 + e - 1); lsb_result = 32'hB000_0000 + 32'(e - 1);
      end else begin
        alu_valid = 1'b0; lsb_valid = 1'b0;
      end
      step();
      exp_v = 1'b0; exp_s = 1'b0; exp_r = '0; exp_d = '0;
      if (e >= 2 && e <= 13) begin
        k = e - 2;
        exp_v = 1'b1;
        exp_s = (k % 2 == 1);
        exp_r = exp_s ? 4'(8 + k / 2) : 4'(k / 2);
        exp_d = (exp_s ? 32'hB000_0000 : 32'hA000_0000) + 32'(k / 2);
      end else if (e == 14) begin
        exp_v = 1'b1; exp_s = 1'b0; exp_r = 4'd6; exp_d = 32'hA000_0006;
      end
      checks++; if (cdb_valid !== exp_v) begin failures++; $display("FAIL fill_valid[e%0d] got=%0h exp=%0h", e, cdb_valid, exp_v); end
      if (exp_v) begin
        checks++; if ({cdb_src, cdb_rob_index, cdb_result} !== {exp_s, exp_r, exp_d}) begin
          failures++; $display("FAIL fill_entry[e%0d] got=s%0h r%0h d%0h exp=s%0h r%0h d%0h", e, cdb_src, cdb_rob_index, cdb_result, exp_s, exp_r, exp_d); end
      end
      if (e == 6) begin
        checks++; if ({alu_ready, lsb_ready} !== 2'b10) begin failures++; $display("FAIL fill_ready_e6 got=%b exp=10", {alu_ready, lsb_ready}); end
      end
      if (e == 7) begin
        checks++; if ({alu_ready, lsb_ready} !== 2'b01) begin failures++; $display("FAIL fill_ready_e7 got=%b exp=01", {alu_ready, lsb_ready}); end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    alu_valid = 1'b1; alu_rob_index = 4'd4; alu_result = 32'h4444_0000;
    lsb_valid = 1'b1; lsb_rob_index = 4'd5; lsb_result = 32'h5555_0000;
    step();
    alu_valid = 1'b0; lsb_valid = 1'b0;
    step();
    checks++; if ({cdb_valid, cdb_src, cdb_rob_index} !== {1'b1, 1'b0, 4'd4}) begin
      failures++; $display("FAIL stall_pre got=v%0h s%0h r%0h exp=v1 s0 r4", cdb_valid, cdb_src, cdb_rob_index); end
    rdy_in = 1'b0;
    // An offer while stalled must not be taken.
    alu_valid = 1'b1; alu_rob_index = 4'd7; alu_result = 32'h7777_0000;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if ({cdb_valid, cdb_src, cdb_rob_index, cdb_result} !== {1'b1, 1'b0, 4'd4, 32'h4444_0000}) begin
        failures++; $display("FAIL stall_hold[%0d] got=v%0h s%0h r%0h d%0h exp=v1 s0 r4 d44440000", c, cdb_valid, cdb_src, cdb_rob_index, cdb_result); end
      checks++; if ({alu_ready, lsb_ready} !== 2'b11) begin failures++; $display("FAIL stall_ready[%0d] got=%b exp=11", c, {alu_ready, lsb_ready}); end
    end
    alu_valid = 1'b0;
    rdy_in = 1'b1;
    step();
    checks++; if ({cdb_valid, cdb_src, cdb_rob_index, cdb_result} !== {1'b1, 1'b1, 4'd5, 32'h5555_0000}) begin
      failures++; $display("FAIL stall_resume got=v%0h s%0h r%0h d%0h exp=v1 s1 r5 d55550000", cdb_valid, cdb_src, cdb_rob_index, cdb_result); end
    step();
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL stall_no_extra got=%0h exp=0", cdb_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    load_both(5);
    // Both queues now hold 3 entries.
    clr_in = 1'b1;
    alu_valid = 1'b1; alu_rob_index = 4'd15; alu_result = 32'hFFFF_0000;
    lsb_valid = 1'b1; lsb_rob_index = 4'd15; lsb_result = 32'hFFFF_0001;
    step();
    clr_in = 1'b0; alu_valid = 1'b0; lsb_valid = 1'b0;
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0h exp=0", cdb_valid); end
    checks++; if ({alu_ready, lsb_ready} !== 2'b11) begin failures++; $display("FAIL flush_ready got=%b exp=11", {alu_ready, lsb_ready}); end
    for (int c = 0; c < 6; c++) begin
      step();
      checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL flush_stale[%0d] got=v%0h r%0h exp=v0", c, cdb_valid, cdb_rob_index); end
    end
    // Make ALU the last grant, then flush while stalled: the next tie must
    // still go to ALU because the flush hands last_grant back to LSB.
    alu_valid = 1'b1; alu_rob_index = 4'd2; alu_result = 32'h0000_0002;
    step();
    alu_valid = 1'b0;
    step();
    checks++; if ({cdb_valid, cdb_src, cdb_rob_index} !== {1'b1, 1'b0, 4'd2}) begin
      failures++; $display("FAIL flush_pre_grant got=v%0h s%0h r%0h exp=v1 s0 r2", cdb_valid, cdb_src, cdb_rob_index); end
    clr_in = 1'b1; rdy_in = 1'b0;
    step();
    clr_in = 1'b0; rdy_in = 1'b1;
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL flush_stalled got=%0h exp=0", cdb_valid); end
    alu_valid = 1'b1; alu_rob_index = 4'd3;  alu_result = 32'h0000_0003;
    lsb_valid = 1'b1; lsb_rob_index = 4'd12; lsb_result = 32'h0000_000C;
    step();
    alu_valid = 1'b0; lsb_valid = 1'b0;
    step();
    checks++; if ({cdb_valid, cdb_src, cdb_rob_index} !== {1'b1, 1'b0, 4'd3}) begin
      failures++; $display("FAIL flush_lastgrant got=v%0h s%0h r%0h exp=v1 s0 r3", cdb_valid, cdb_src, cdb_rob_index); end
    step();
    checks++; if ({cdb_valid, cdb_src, cdb_rob_index} !== {1'b1, 1'b1, 4'd12}) begin
      failures++; $display("FAIL flush_second got=v%0h s%0h r%0h exp=v1 s1 r12", cdb_valid, cdb_src, cdb_rob_index); end
  endtask

  task automatic test_async_reset();
    do_reset();
    load_both(7);
    // ALU queue full, LSB holds 3, cdb shows L2 (rob 10).
    checks++; if ({alu_ready, cdb_valid, cdb_src, cdb_rob_index} !== {1'b0, 1'b1, 1'b1, 4'd10}) begin
      failures++; $display("FAIL arst_pre got=rdy%0h v%0h s%0h r%0h exp=rdy0 v1 s1 ra", alu_ready, cdb_valid, cdb_src, cdb_rob_index); end
    #2;
    rst_in = 1'b1;
    #1;
    checks++; if ({cdb_valid, cdb_src, cdb_rob_index, cdb_result} !== {1'b0, 1'b0, 4'd0, 32'd0}) begin
      failures++; $display("FAIL arst_outputs got=v%0h s%0h r%0h d%0h exp=all0", cdb_valid, cdb_src, cdb_rob_index, cdb_result); end
    checks++; if ({alu_ready, lsb_ready} !== 2'b11) begin failures++; $display("FAIL arst_ready got=%b exp=11", {alu_ready, lsb_ready}); end
    #2;
    rst_in = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL arst_discard[%0d] got=v%0h r%0h exp=v0", c, cdb_valid, cdb_rob_index); end
    end
  endtask

  initial begin
    idle_inputs();
    rst_in = 1'b1;
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_fill();
    test_stall();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
